// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame collector: frame geometry helpers,
// FSM state encoding and the running checksum step.
package uart_frame_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_COLLECT = 1'b1;

  localparam int CHK_W = 32;

  function automatic int bytes_per_data(input int data_size, input int trama_size);
    return (data_size + trama_size - 1) / trama_size;
  endfunction

  // One opcode byte always follows the operands; a checksum byte is optional.
  function automatic int frame_bytes(input int n_operands, input int data_size,
                                     input int trama_size, input bit chk_en);
    return n_operands * bytes_per_data(data_size, trama_size) + 1 + (chk_en ? 1 : 0);
  endfunction

  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] acc,
                                                  input logic [CHK_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Output holding register for completed frames with load/accept/overrun logic.
module frame_out_reg #(
  parameter int OPS_W       = 16,
  parameter int OPCODE_SIZE = 6
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   load,
  input  logic [OPS_W-1:0]       load_operands,
  input  logic [OPCODE_SIZE-1:0] load_opcode,
  input  logic                   ready,
  output logic [OPS_W-1:0]       operands,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   valid,
  output logic                   overrun
);

  // Handshake: valid stays high with operands/opcode frozen until the edge
  // where valid && ready; a load on that same edge replaces the frame and
  // keeps valid high, while a load into a held, unaccepted frame is dropped
  // and flagged with a one-cycle overrun pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      operands <= '0;
      opcode   <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!valid || ready) begin
          operands <= load_operands;
          opcode   <= load_opcode;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_frame_collector.sv
// Assembles operands and an opcode from UART RX bytes into a valid/ready frame.
// Optional trailing XOR checksum byte enabled by UART_FRAME_CHECKSUM_EN.
module uart_frame_collector
  import uart_frame_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int TRAMA_SIZE     = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int N_OPERANDS     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_rx_done,
  input  logic [TRAMA_SIZE-1:0]            i_rx_byte,
  output logic [N_OPERANDS*DATA_SIZE-1:0]  o_operands,
  output logic [OPCODE_SIZE-1:0]           o_opcode,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_overrun,
  output logic                             o_timeout,
  output logic                             o_chk_err,
  output state_t                           dbg_state
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int BPD         = bytes_per_data(DATA_SIZE, TRAMA_SIZE);
  localparam int DATA_BYTES  = N_OPERANDS * BPD;
  localparam int FRAME_BYTES = frame_bytes(N_OPERANDS, DATA_SIZE, TRAMA_SIZE, CHK_EN);
  localparam int OPS_W       = N_OPERANDS * DATA_SIZE;
  localparam int CNT_W       = $clog2(FRAME_BYTES);
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] OPCODE_IDX = CNT_W'(DATA_BYTES);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                             state_q;
  logic [CNT_W-1:0]                   count_q;
  logic [TO_W-1:0]                    to_cnt_q;
  logic [DATA_BYTES*TRAMA_SIZE-1:0]   data_buf_q;
  logic                               timeout_q;
  logic                               last_byte;
  logic                               expire;
  logic                               load_req;
  logic [OPS_W-1:0]                   load_ops;
  logic [OPCODE_SIZE-1:0]             load_opc;

  assign last_byte = i_rx_done && (count_q == LAST_IDX);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire    = (state_q == ST_COLLECT) && !i_rx_done && (to_cnt_q == TO_LAST);
  assign dbg_state = state_q;
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (i_rx_done) begin
        to_cnt_q <= '0;
        if (last_byte) begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end else begin
          state_q <= ST_COLLECT;
          count_q <= count_q + 1'b1;
        end
      end else if (expire) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        to_cnt_q  <= '0;
        timeout_q <= 1'b1;
      end else if (state_q == ST_COLLECT) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  // Operand bytes land little-endian in a flat buffer indexed by byte count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_buf_q <= '0;
    end else begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (i_rx_done && (count_q == CNT_W'(b))) begin
          data_buf_q[b*TRAMA_SIZE +: TRAMA_SIZE] <= i_rx_byte;
        end
      end
    end
  end

  for (genvar k = 0; k < N_OPERANDS; k++) begin : g_ops
    assign load_ops[k*DATA_SIZE +: DATA_SIZE] = data_buf_q[k*BPD*TRAMA_SIZE +: DATA_SIZE];
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [TRAMA_SIZE-1:0] acc_q;
  logic [TRAMA_SIZE-1:0] op_byte_q;
  logic                  chk_err_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q     <= '0;
      op_byte_q <= '0;
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= last_byte && (acc_q != i_rx_byte);
      if (i_rx_done) begin
        acc_q <= (count_q == '0) ? i_rx_byte
                                 : TRAMA_SIZE'(chk_update(CHK_W'(acc_q), CHK_W'(i_rx_byte)));
        if (count_q == OPCODE_IDX) begin
          op_byte_q <= i_rx_byte;
        end
      end
    end
  end

  assign load_req  = last_byte && (acc_q == i_rx_byte);
  assign load_opc  = op_byte_q[OPCODE_SIZE-1:0];
  assign o_chk_err = chk_err_q;
`else
  assign load_req  = last_byte;
  assign load_opc  = i_rx_byte[OPCODE_SIZE-1:0];
  assign o_chk_err = 1'b0;
`endif

  frame_out_reg #(
    .OPS_W       (OPS_W),
    .OPCODE_SIZE (OPCODE_SIZE)
  ) u_out (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .load          (load_req),
    .load_operands (load_ops),
    .load_opcode   (load_opc),
    .ready         (i_ready),
    .operands      (o_operands),
    .opcode        (o_opcode),
    .valid         (o_valid),
    .overrun       (o_overrun)
  );

endmodule

// File: tb/tb_uart_frame_collector.sv
// Bench for uart_frame_collector: directed scenarios plus random traffic
// against a byte-queue reference model; honours UART_FRAME_CHECKSUM_EN.
module tb_uart_frame_collector;

  localparam int DATA_SIZE      = 8;
  localparam int TRAMA_SIZE     = 8;
  localparam int OPCODE_SIZE    = 6;
  localparam int N_OPERANDS     = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int BPD            = (DATA_SIZE + TRAMA_SIZE - 1) / TRAMA_SIZE;
  localparam int DATA_BYTES     = N_OPERANDS * BPD;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int FRAME_BYTES = DATA_BYTES + 1 + CHK;
  localparam int OPS_W       = N_OPERANDS * DATA_SIZE;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   rx_done = 1'b0;
  logic [TRAMA_SIZE-1:0]  rx_byte = '0;
  logic                   ready = 1'b0;
  logic [OPS_W-1:0]       operands;
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   valid;
  logic                   overrun;
  logic                   timeout;
  logic                   chk_err;
  logic [0:0]             dbg_state;

  always #5 clk = ~clk;

  uart_frame_collector #(
    .DATA_SIZE      (DATA_SIZE),
    .TRAMA_SIZE     (TRAMA_SIZE),
    .OPCODE_SIZE    (OPCODE_SIZE),
    .N_OPERANDS     (N_OPERANDS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx_done  (rx_done),
    .i_rx_byte  (rx_byte),
    .o_operands (operands),
    .o_opcode   (opcode),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_overrun  (overrun),
    .o_timeout  (timeout),
    .o_chk_err  (chk_err),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: partial frame as a byte queue, idle cycle count, held frame.
  logic [TRAMA_SIZE-1:0]        mq[$];
  int                           m_idle = 0;
  logic                         m_valid = 1'b0;
  logic [OPS_W-1:0]             m_ops = '0;
  logic [OPCODE_SIZE-1:0]       m_opc = '0;
  logic                         m_ovr = 1'b0;
  logic                         m_to  = 1'b0;
  logic                         m_chk = 1'b0;
  logic [OPS_W+OPCODE_SIZE-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic rx, input logic [7:0] b, input logic rdy);
    logic                   load;
    logic [OPS_W-1:0]       f_ops;
    logic [OPCODE_SIZE-1:0] f_opc;
    logic [TRAMA_SIZE-1:0]  x;
    logic [31:0]            v;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_idle = 0; m_valid = 1'b0; m_ops = '0; m_opc = '0;
      m_ovr = 1'b0; m_to = 1'b0; m_chk = 1'b0;
      return;
    end
    load = 1'b0; f_ops = '0; f_opc = '0;
    m_ovr = 1'b0; m_to = 1'b0; m_chk = 1'b0;
    if (rx) begin
      mq.push_back(b);
      m_idle = 0;
      if (mq.size() == FRAME_BYTES) begin
        for (int k = 0; k < N_OPERANDS; k++) begin
          v = 0;
          for (int j = BPD - 1; j >= 0; j--) v = (v << TRAMA_SIZE) | 32'(mq[k*BPD+j]);
          f_ops[k*DATA_SIZE +: DATA_SIZE] = v[DATA_SIZE-1:0];
        end
        x = mq[DATA_BYTES];
        f_opc = x[OPCODE_SIZE-1:0];
        x = '0;
        for (int i = 0; i < FRAME_BYTES - 1; i++) x = x ^ mq[i];
        if (CHK != 0 && x != mq[FRAME_BYTES-1]) m_chk = 1'b1;
        else load = 1'b1;
        mq.delete();
      end
    end else if (mq.size() != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYCLES) begin
        mq.delete();
        m_idle = 0;
        m_to = 1'b1;
      end
    end
    if (load) begin
      if (!m_valid || rdy) begin
        m_ops = f_ops; m_opc = f_opc; m_valid = 1'b1;
        exp_q.push_back({f_opc, f_ops});
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic rx, input logic [7:0] b, input logic rdy);
    logic [OPS_W+OPCODE_SIZE-1:0] e;
    @(negedge clk);
    reset = rst; rx_done = rx; rx_byte = b; ready = rdy;
    if (!rst && valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_accept", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_frame", 32'({opcode, operands}), 32'(e));
      end
    end
    model_step(rst, rx, b, rdy);
    @(posedge clk);
    #1;
    check("valid",    32'(valid),    32'(m_valid));
    check("operands", 32'(operands), 32'(m_ops));
    check("opcode",   32'(opcode),   32'(m_opc));
    check("overrun",  32'(overrun),  32'(m_ovr));
    check("timeout",  32'(timeout),  32'(m_to));
    check("chk_err",  32'(chk_err),  32'(m_chk));
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] op,
                            input logic rdy_body, input logic rdy_last);
    step(1'b0, 1'b1, b0, rdy_body);
    step(1'b0, 1'b1, b1, rdy_body);
`ifdef UART_FRAME_CHECKSUM_EN
    step(1'b0, 1'b1, op, rdy_body);
    step(1'b0, 1'b1, b0 ^ b1 ^ op, rdy_last);
`else
    step(1'b0, 1'b1, op, rdy_last);
`endif
  endtask

  initial begin
    logic       rx, rdy, rst;
    logic [7:0] b;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_valid",    32'(valid),    32'(0));
    check("rst_operands", 32'(operands), 32'(0));
    check("rst_overrun",  32'(overrun),  32'(0));

    // Basic frame, accepted one cycle after it appears
    send_frame(8'h05, 8'h03, 8'h20, 1'b0, 1'b0);
    check("basic_valid",    32'(valid),    32'(1));
    check("basic_operands", 32'(operands), 32'h0305);
    check("basic_opcode",   32'(opcode),   32'h20);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("basic_cleared",  32'(valid),    32'(0));

    // Opcode upper bits ignored
    send_frame(8'hAA, 8'h55, 8'hFF, 1'b1, 1'b1);
    check("trunc_operands", 32'(operands), 32'h55AA);
    check("trunc_opcode",   32'(opcode),   32'h3F);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Inter-byte timeout drops the partial frame
    step(1'b0, 1'b1, 8'h05, 1'b0);
    idle(TIMEOUT_CYCLES, 1'b0);
    check("to_pulse", 32'(timeout), 32'(1));
    check("to_novalid", 32'(valid), 32'(0));
    send_frame(8'h07, 8'h02, 8'h22, 1'b0, 1'b0);
    check("to_next_operands", 32'(operands), 32'h0207);
    check("to_next_opcode",   32'(opcode),   32'h22);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Overrun while stalled, then load+accept on the same edge
    send_frame(8'h11, 8'h22, 8'h01, 1'b0, 1'b0);
    send_frame(8'h33, 8'h44, 8'h02, 1'b0, 1'b0);
    check("ovr_pulse",    32'(overrun),  32'(1));
    check("ovr_held_ops", 32'(operands), 32'h2211);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovr_single",   32'(overrun),  32'(0));
    send_frame(8'h11, 8'h22, 8'h01, 1'b0, 1'b0);
    send_frame(8'h33, 8'h44, 8'h02, 1'b0, 1'b1);
    check("swap_valid",   32'(valid),    32'(1));
    check("swap_ops",     32'(operands), 32'h4433);
    check("swap_no_ovr",  32'(overrun),  32'(0));
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset in the middle of a frame
    step(1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("midrst_valid", 32'(valid),    32'(0));
    check("midrst_ops",   32'(operands), 32'(0));
    send_frame(8'h07, 8'h02, 8'h22, 1'b0, 1'b0);
    check("midrst_next_ops", 32'(operands), 32'h0207);
    step(1'b0, 1'b0, 8'h00, 1'b1);

`ifdef UART_FRAME_CHECKSUM_EN
    step(1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b1, 8'h26, 1'b0);
    check("chk_good_valid", 32'(valid), 32'(1));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b1, 8'h27, 1'b0);
    check("chk_bad_err",   32'(chk_err), 32'(1));
    check("chk_bad_valid", 32'(valid),   32'(0));
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) idle(TIMEOUT_CYCLES + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      rx  = ($urandom_range(0, 2) != 0);
      b   = 8'($urandom_range(0, 255));
`ifdef UART_FRAME_CHECKSUM_EN
      if (rx && mq.size() == FRAME_BYTES - 1 && $urandom_range(0, 4) != 0) begin
        b = '0;
        foreach (mq[q]) b = b ^ mq[q];
      end
`endif
      rdy = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(rst, rx, b, rdy);
    end
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_collector.md
Name: uart_frame_collector

Overview:
Parametrised successor to the ALU operand collector. It assembles N_OPERANDS operands plus one opcode from a stream of UART RX bytes and presents the completed frame on a valid/ready output register. It also discards stale partial frames after an inter-byte timeout and reports overrun when the consumer stalls. It sits between uart_rx and the ALU/command stage.

Parameters:
- DATA_SIZE, 8, bits per operand.
- TRAMA_SIZE, 8, bits per RX byte.
- OPCODE_SIZE, 6, opcode bits; must be <= TRAMA_SIZE.
- N_OPERANDS, 2, operands per frame, 1..8.
- TIMEOUT_CYCLES, 100000, idle cycles before a partial frame is dropped; must be >= 1.
- Derived: BYTES_PER_DATA = ceil(DATA_SIZE/TRAMA_SIZE).
- Derived: FRAME_BYTES = N_OPERANDS*BYTES_PER_DATA + 1 (+1 more with checksum enabled).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle strobe; i_rx_byte is valid on this cycle.
- i_rx_byte  in  TRAMA_SIZE  received byte.
- o_operands  out  N_OPERANDS*DATA_SIZE  operand k occupies bits [k*DATA_SIZE +: DATA_SIZE].
- o_opcode  out  OPCODE_SIZE  frame opcode.
- o_valid  out  1  frame available.
- i_ready  in  1  consumer accepts the frame when o_valid && i_ready.
- o_overrun  out  1  one-cycle pulse: completed frame dropped.
- o_timeout  out  1  one-cycle pulse: partial frame discarded.
- o_chk_err  out  1  one-cycle pulse: checksum mismatch (constant 0 without the feature).

Behaviour:
- Reset: byte count, timeout counter, o_operands, o_opcode, o_valid, and all pulse outputs go to 0. Reset mid-frame discards the partial frame.
- Byte order per frame: operand 0, operand 1, ..., operand N-1, then the opcode byte. Each operand is BYTES_PER_DATA bytes, little-endian, truncated to DATA_SIZE bits. Opcode = low OPCODE_SIZE bits of its byte; upper bits are ignored.
- Assembly buffer is separate from the output register, so a frame is collected while the previous frame is still pending.
- FSM states:
  - IDLE (count=0) -> COLLECT on i_rx_done.
  - COLLECT: count increments on each i_rx_done.
  - On the final byte: return to IDLE and issue a load request.
- Load latency: o_valid rises on the clock edge after the final byte's i_rx_done cycle, with o_operands and o_opcode stable.
- Handshake:
  - o_valid holds, with data stable, until o_valid && i_ready; it clears on that edge unless a new load occurs on the same edge.
  - Load and accept on the same edge: new frame loads, o_valid stays 1, no overrun.
  - Load while o_valid=1 and i_ready=0: new frame dropped, held frame unchanged, o_overrun pulses one cycle.
- Timeout:
  - Counter runs only in COLLECT and resets on every i_rx_done.
  - When the counter reaches TIMEOUT_CYCLES: return to IDLE, count=0, o_timeout pulses one cycle.
  - i_rx_done on the same cycle as expiry: the byte wins and the counter resets.
- Counter widths are $clog2-derived. No wrap-around is possible, because the count saturates at the frame end.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - One trailing checksum byte is appended per frame, equal to the XOR of all preceding frame bytes.
  - On mismatch the frame is not loaded and o_chk_err pulses one cycle; o_overrun is not raised.
  - A timeout while waiting for the checksum byte behaves as any other timeout.
- Undefined: no checksum byte is expected, and o_chk_err is tied to 0.

Decomposition:
- Package uart_frame_pkg: derived constants BYTES_PER_DATA and FRAME_BYTES, the FSM state typedef (IDLE, COLLECT), and a checksum function.
- Sub-module frame_out_reg: the valid/ready output register with load/accept/overrun logic.
- Top level holds the FSM, byte buffer, and timeout counter.

Test Plan:
- Defaults: bytes 0x05, 0x03, 0x20 -> o_operands=0x0305, o_opcode=0x20, o_valid the edge after the third strobe; i_ready=1 clears o_valid next edge.
- Opcode byte 0xFF -> o_opcode=0x3F; operand bytes 0xAA, 0x55 -> o_operands=0x55AA.
- TIMEOUT_CYCLES=16: send 0x05, idle 16 cycles -> o_timeout pulse, no o_valid. Then 0x07, 0x02, 0x22 -> o_operands=0x0207, o_opcode=0x22.
- i_ready=0 with two full frames sent -> first frame held unchanged, o_overrun pulses once. Repeat with i_ready=1 on the load edge -> second frame loads, no overrun.
- Reset asserted after 2 of 3 bytes -> all outputs 0. Next full frame decodes correctly.
- UART_FRAME_CHECKSUM_EN: 0x05, 0x03, 0x20, 0x26 -> valid frame. Same bytes with checksum 0x27 -> o_chk_err pulse, o_valid stays 0.
